// File: rtl/input_capture.sv
// Board input conditioning: synchronizes switches and the centre button, debounces the
// button, and offers the switch word captured on each press to the CPU via valid/ack.
module input_capture #(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SW_WIDTH-1:0] SW,
  input  logic                BTNC,
  output logic [SW_WIDTH-1:0] sw_sync,
  output logic                btn_level,
  output logic                press_pulse,
  output logic [SW_WIDTH-1:0] data,
  output logic                data_valid,
  input  logic                data_ack,
  output logic                overrun
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } state_t;

  logic [SW_WIDTH-1:0] sw_meta_r;
  logic                btn_meta_r;
  logic                btn_s_r;
  state_t              state_r;
  state_t              state_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_s;
  logic                level_s;
  logic                pulse_s;
  logic [SW_WIDTH-1:0] data_s;
  logic                valid_s;
  logic                overrun_s;

  // Two-flop synchronizers for the switch bus and the button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_r  <= {SW_WIDTH{1'b0}};
      sw_sync    <= {SW_WIDTH{1'b0}};
      btn_meta_r <= 1'b0;
      btn_s_r    <= 1'b0;
    end else begin
      sw_meta_r  <= SW;
      sw_sync    <= sw_meta_r;
      btn_meta_r <= BTNC;
      btn_s_r    <= btn_meta_r;
    end
  end

  // Debounce next-state: the level flips only after DEBOUNCE_CYCLES consecutive opposing samples.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    level_s = btn_level;
    pulse_s = 1'b0;
    case (state_r)
      RELEASED: begin
        if (btn_s_r) begin
          state_s = PRESS_WAIT;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s   = CNT_ZERO;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s_r) begin
          state_s = RELEASED;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_s = PRESSED;
          cnt_s   = CNT_ZERO;
          level_s = 1'b1;
          pulse_s = 1'b1;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s_r) begin
          state_s = RELEASE_WAIT;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = PRESSED;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s_r) begin
          state_s = PRESSED;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_s = RELEASED;
          cnt_s   = CNT_ZERO;
          level_s = 1'b0;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = RELEASED;
        cnt_s   = CNT_ZERO;
        level_s = 1'b0;
      end
    endcase
  end

  // Capture/handshake next-state; the press is acted on at the same edge that raises press_pulse.
  always_comb begin
    data_s    = data;
    valid_s   = data_valid;
    overrun_s = overrun;
    if (data_valid && data_ack) begin
      overrun_s = 1'b0;
    end else begin
      overrun_s = overrun;
    end
    if (pulse_s) begin
      if (!data_valid || data_ack) begin
        data_s  = sw_sync;
        valid_s = 1'b1;
      end else begin
        overrun_s = 1'b1;
      end
    end else if (data_valid && data_ack) begin
      valid_s = 1'b0;
    end else begin
      valid_s = data_valid;
    end
  end

  // Debounce and capture state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RELEASED;
      cnt_r       <= CNT_ZERO;
      btn_level   <= 1'b0;
      press_pulse <= 1'b0;
      data        <= {SW_WIDTH{1'b0}};
      data_valid  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      btn_level   <= level_s;
      press_pulse <= pulse_s;
      data        <= data_s;
      data_valid  <= valid_s;
      overrun     <= overrun_s;
    end
  end

endmodule

// File: tb/tb_input_capture.sv
// Self-checking bench for input_capture: directed scenarios plus randomized button/switch/ack
// traffic compared every cycle against a run-length debounce model.
module tb_input_capture;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] sw;
  logic         btnc;
  logic         data_ack;
  logic [W-1:0] sw_sync;
  logic         btn_level;
  logic         press_pulse;
  logic [W-1:0] data;
  logic         data_valid;
  logic         overrun;

  input_capture #(.SW_WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .SW(sw), .BTNC(btnc),
    .sw_sync(sw_sync), .btn_level(btn_level), .press_pulse(press_pulse),
    .data(data), .data_valid(data_valid), .data_ack(data_ack), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: delay lines for the synchronizers, a run counter for debounce.
  logic [W-1:0] m_sw_d1, m_sw_sync;
  logic         m_btn_d1, m_btn_s;
  int           m_run;
  logic         m_level, m_pulse, m_dv, m_ovr;
  logic [W-1:0] m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sw_d1 = '0; m_sw_sync = '0; m_btn_d1 = 1'b0; m_btn_s = 1'b0;
    m_run = 0; m_level = 1'b0; m_pulse = 1'b0; m_dv = 1'b0; m_ovr = 1'b0; m_data = '0;
  endtask

  task automatic model_edge();
    logic press;
    press = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_btn_s != m_level) begin
        m_run++;
        if (m_run == N) begin
          m_level = ~m_level;
          m_run   = 0;
          press   = m_level;
        end
      end else begin
        m_run = 0;
      end
      if (m_dv && data_ack) m_ovr = 1'b0;
      if (press) begin
        if (!m_dv || data_ack) begin
          m_data = m_sw_sync;
          m_dv   = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_dv && data_ack) begin
        m_dv = 1'b0;
      end
      m_pulse   = press;
      m_sw_sync = m_sw_d1;
      m_sw_d1   = sw;
      m_btn_s   = m_btn_d1;
      m_btn_d1  = btnc;
    end
  endtask

  task automatic compare_all();
    check("sw_sync", sw_sync, m_sw_sync);
    check("btn_level", btn_level, m_level);
    check("press_pulse", press_pulse, m_pulse);
    check("data", data, m_data);
    check("data_valid", data_valid, m_dv);
    check("overrun", overrun, m_ovr);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Press with switch value v; pulse_at returns the edge index (after BTNC rise) of the pulse.
  task automatic do_press(input logic [W-1:0] v, input bit ack_at_pulse, output int pulse_at);
    pulse_at = -1;
    sw = v;
    repeat (3) cycle();
    btnc = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      data_ack = (ack_at_pulse && i == 6);
      cycle();
      if (press_pulse === 1'b1 && pulse_at < 0) pulse_at = i;
    end
    data_ack = 1'b0;
    btnc = 1'b0;
    repeat (N + 4) cycle();
  endtask

  int  pulse_at;
  bit  saw_pulse, saw_level;
  int  run_left;

  initial begin
    rst_n = 1'b0; sw = '0; btnc = 1'b0; data_ack = 1'b0;
    model_reset();
    #12;
    check("reset_data_valid", data_valid, 1'b0);
    check("reset_sw_sync", sw_sync, 16'h0000);
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (2) cycle();

    // Clean press.
    do_press(16'hA5C3, 1'b0, pulse_at);
    check("clean_pulse_edge", pulse_at, 6);
    check("clean_data", data, 16'hA5C3);
    check("clean_valid", data_valid, 1'b1);

    // Handshake.
    data_ack = 1'b1;
    cycle();
    data_ack = 1'b0;
    check("ack_valid", data_valid, 1'b0);
    check("ack_data", data, 16'hA5C3);
    repeat (2) cycle();

    // Bounce.
    saw_pulse = 1'b0; saw_level = 1'b0;
    btnc = 1'b1; repeat (3) cycle();
    btnc = 1'b0; cycle();
    btnc = 1'b1; repeat (2) cycle();
    btnc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (press_pulse) saw_pulse = 1'b1;
      if (btn_level) saw_level = 1'b1;
    end
    check("bounce_pulse", saw_pulse, 1'b0);
    check("bounce_level", saw_level, 1'b0);
    check("bounce_valid", data_valid, 1'b0);

    // Overrun.
    do_press(16'h0001, 1'b0, pulse_at);
    do_press(16'h0002, 1'b0, pulse_at);
    check("ovr_data", data, 16'h0001);
    check("ovr_flag", overrun, 1'b1);
    data_ack = 1'b1;
    cycle();
    data_ack = 1'b0;
    check("ovr_ack_valid", data_valid, 1'b0);
    check("ovr_ack_flag", overrun, 1'b0);

    // Simultaneous press and ack.
    do_press(16'h0001, 1'b0, pulse_at);
    do_press(16'h0002, 1'b1, pulse_at);
    check("sim_data", data, 16'h0002);
    check("sim_valid", data_valid, 1'b1);
    check("sim_overrun", overrun, 1'b0);

    // Asynchronous reset mid-cycle with button held and data pending.
    sw = 16'hFFFF; btnc = 1'b1;
    repeat (4) cycle();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_sw_sync", sw_sync, 16'h0000);
    check("async_data", data, 16'h0000);
    check("async_valid", data_valid, 1'b0);
    check("async_level", btn_level, 1'b0);
    repeat (2) cycle();
    #2;
    rst_n = 1'b1;
    repeat (12) cycle();

    // Randomized traffic.
    run_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        btnc = ~btnc;
        run_left = $urandom_range(1, 8);
      end
      run_left--;
      if ($urandom_range(0, 15) == 0) sw = W'($urandom);
      data_ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 799) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        cycle();
        #2;
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
